// File: rtl/snake_pkg.sv
// snake_pkg: shared playfield geometry, cake placement defaults and state type
package snake_pkg;
  localparam int DEF_GRID_W    = 40;
  localparam int DEF_GRID_H    = 30;
  localparam int DEF_CELL_LOG2 = 4;
  localparam int DEF_MAX_TRIES = 8;
  localparam int XW            = 6;
  localparam int YW            = 5;
  localparam int SCAN_W        = 11;
  typedef enum logic [2:0] {
    IDLE,
    SAMPLE_X,
    SAMPLE_Y,
    QUERY,
    SCAN,
    PLACED,
    FULL
  } cake_state_t;
endpackage

// File: rtl/cake_scan_ctr.sv
// cake_scan_ctr: wrap-around cell stepper with visited-cell counter for the fallback scan
module cake_scan_ctr
  import snake_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] ld_x,
  input  logic [YW-1:0] ld_y,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          full
);
  localparam logic [XW-1:0]     XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0]     YMAX = YW'(GRID_H - 1);
  localparam logic [SCAN_W-1:0] LAST = SCAN_W'(GRID_W * GRID_H - 1);
  logic [SCAN_W-1:0] cnt;
  // full flags the current cell as the last unvisited one, so a hit on it ends the scan
  assign full = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      cnt <= '0;
    end else if (load) begin
      x   <= ld_x;
      y   <= ld_y;
      cnt <= '0;
    end else if (step) begin
      x   <= x == XMAX ? '0 : x + 1'b1;
      y   <= x != XMAX ? y : y == YMAX ? '0 : y + 1'b1;
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/cake_ctrl.sv
// cake_ctrl: picks a free playfield cell for the cake via random tries, then a linear scan
module cake_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W    = DEF_GRID_W,
  parameter int GRID_H    = DEF_GRID_H,
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [8:0]    rand_num,
  input  logic          eat,
  output logic          occ_req,
  output logic [XW-1:0] occ_x,
  output logic [YW-1:0] occ_y,
  input  logic          occ_ack,
  input  logic          occ_hit,
  output logic [9:0]    box_x,
  output logic [9:0]    box_y,
  output logic          food_valid,
  output logic          placed,
  output logic          busy,
  output logic          board_full
);
  localparam int            TW   = $clog2(MAX_TRIES + 1);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
  cake_state_t   state, state_nx;
  logic [XW-1:0] cx, qx, sx;
  logic [YW-1:0] qy, sy;
  logic [TW-1:0] tries;
  logic          start, x_ok, y_ok, fail, tries_out, scan_load, scan_step, scan_full;
  logic          unused_rand;
  assign unused_rand = ^rand_num[8:XW];
  // food_valid is low in IDLE only straight after reset, which starts the first cake
  assign start     = state == IDLE && (eat || !food_valid);
  assign x_ok      = rand_num[XW-1:0] <= XMAX;
  assign y_ok      = rand_num[YW-1:0] <= YMAX;
  assign fail      = (state == SAMPLE_X && !x_ok) || (state == SAMPLE_Y && !y_ok) ||
                     (state == QUERY && occ_ack && occ_hit);
  assign tries_out = fail && tries == TW'(MAX_TRIES - 1);
  assign scan_load = state != SCAN && state_nx == SCAN;
  assign scan_step = state == SCAN && occ_ack && occ_hit;
  assign occ_req    = state == QUERY || state == SCAN;
  assign occ_x      = state == SCAN ? sx : qx;
  assign occ_y      = state == SCAN ? sy : qy;
  assign busy       = occ_req || state == SAMPLE_X || state == SAMPLE_Y;
  assign placed     = state == PLACED;
  assign board_full = state == FULL;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? SAMPLE_X : IDLE;
      SAMPLE_X: state_nx = tries_out ? SCAN : x_ok ? SAMPLE_Y : SAMPLE_X;
      SAMPLE_Y: state_nx = tries_out ? SCAN : y_ok ? QUERY : SAMPLE_X;
      QUERY:    state_nx = !occ_ack ? QUERY : tries_out ? SCAN : occ_hit ? SAMPLE_X : PLACED;
      SCAN:     state_nx = !occ_ack ? SCAN : !occ_hit ? PLACED : scan_full ? FULL : SCAN;
      PLACED:   state_nx = IDLE;
      default:  state_nx = state;
    endcase
  end
  // qx/qy hold the last in-range candidate, which also seeds the fallback scan
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cx         <= '0;
      qx         <= '0;
      qy         <= '0;
      tries      <= '0;
      food_valid <= 1'b0;
      box_x      <= '0;
      box_y      <= '0;
    end else begin
      state <= state_nx;
      if (state == SAMPLE_X) cx <= rand_num[XW-1:0];
      if (start) begin
        tries <= '0;
        qx    <= '0;
        qy    <= '0;
      end else begin
        if (fail) tries <= tries + 1'b1;
        if (state == SAMPLE_Y && y_ok) begin
          qx <= cx;
          qy <= rand_num[YW-1:0];
        end
      end
      if (start) food_valid <= 1'b0;
      else if (state_nx == PLACED) food_valid <= 1'b1;
      if (state_nx == PLACED) begin
        box_x <= 10'(occ_x) << CELL_LOG2;
        box_y <= 10'(occ_y) << CELL_LOG2;
      end
    end
  cake_scan_ctr #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .load (scan_load),
    .step (scan_step),
    .ld_x (qx),
    .ld_y (qy),
    .x    (sx),
    .y    (sy),
    .full (scan_full)
  );
endmodule

// File: tb/tb_cake_ctrl.sv
// tb_cake_ctrl: randomized bench for cake_ctrl against a placement-algorithm reference model
module tb_cake_ctrl;
  logic clk = 0, rst_n = 0, eat = 0, occ_ack = 0, occ_hit = 0;
  logic [8:0] rand_num = 0;
  logic occ_req, food_valid, placed, busy, board_full;
  logic [5:0] occ_x;
  logic [4:0] occ_y;
  logic [9:0] box_x, box_y;
  int n_cmp = 0, n_bad = 0, cyc = 0, lat = 1;
  bit resp_en = 1;
  logic [8:0] rtrace[int];
  logic [8:0] fixed[int];
  bit occ[0:39][0:29];
  int obs_q[$], exp_q[$];
  int exp_edge, exp_x, exp_y, n_rand;
  bit exp_full;

  cake_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rand_num(rand_num), .eat(eat),
    .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y), .occ_ack(occ_ack), .occ_hit(occ_hit),
    .box_x(box_x), .box_y(box_y), .food_valid(food_valid), .placed(placed),
    .busy(busy), .board_full(board_full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // rtrace[k] is the rand_num value the DUT sees at posedge number k
  initial forever begin
    @(negedge clk);
    rand_num = fixed.exists(cyc + 1) ? fixed[cyc + 1] : 9'($urandom_range(0, 511));
    rtrace[cyc + 1] = rand_num;
  end

  // occupancy responder: ack in the (lat+1)-th cycle of each request
  initial begin
    int w = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) w = 0;
      else begin
        occ_ack = 0;
        occ_hit = 0;
        if (!occ_req) w = 0;
        else begin
          w++;
          if (w == lat + 1) begin
            w = 0;
            occ_ack = 1;
            n_cmp++;
            if (occ_x >= 40 || occ_y >= 30) begin
              n_bad++;
              $display("FAIL occ_range: got cell (%0d,%0d) want inside 40x30", occ_x, occ_y);
              occ_hit = 1;
            end else occ_hit = occ[occ_x][occ_y];
            obs_q.push_back(occ_x * 32 + occ_y);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic int rt(input int p);
    return rtrace.exists(p) ? int'(rtrace[p]) : 0;
  endfunction

  // placement algorithm: random tries from the rand trace, then linear scan from the last candidate
  function automatic void model(input int s);
    int p = s + 1, tries = 0, lx = 0, ly = 0, x, y, t = 0;
    exp_q.delete();
    exp_full = 0;
    n_rand = 0;
    while (tries < 8) begin
      x = rt(p) % 64; t = p; p++;
      if (x >= 40) begin tries++; continue; end
      y = rt(p) % 32; t = p; p++;
      if (y >= 30) begin tries++; continue; end
      lx = x; ly = y;
      exp_q.push_back(x * 32 + y);
      n_rand++;
      t = p + lat;
      if (!occ[x][y]) begin exp_x = x; exp_y = y; exp_edge = t; return; end
      tries++;
      p = t + 1;
    end
    for (int i = 0; i < 1200; i++) begin
      exp_q.push_back(lx * 32 + ly);
      t += lat + 1;
      if (!occ[lx][ly]) begin exp_x = lx; exp_y = ly; exp_edge = t; return; end
      if (lx == 39) begin lx = 0; ly = ly == 29 ? 0 : ly + 1; end
      else lx++;
    end
    exp_full = 1;
    exp_edge = t;
  endfunction

  function automatic int q_diff();
    int d = obs_q.size() == exp_q.size() ? 0 : 1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) d++;
    return d;
  endfunction

  task automatic fill_occ(input int dens);
    for (int i = 0; i < 40; i++) for (int j = 0; j < 30; j++) occ[i][j] = $urandom_range(0, 99) < dens;
  endtask

  task automatic pulse_eat(output int s);
    @(negedge clk);
    obs_q.delete();
    eat = 1;
    s = cyc + 1;
    @(negedge clk);
    eat = 0;
  endtask

  task automatic wait_done(output int e, output int npl, output bit to);
    npl = 0; to = 1; e = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (placed) npl++;
      if (placed || board_full) begin e = cyc; to = 0; return; end
    end
  endtask

  task automatic test_reset();
    int s, e, npl; bit to;
    rst_n = 0; lat = 1; fill_occ(0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({occ_req, food_valid, placed, busy, board_full} !== 5'b0 || box_x !== 0 || box_y !== 0 || occ_x !== 0 || occ_y !== 0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b fv=%b pl=%b busy=%b full=%b box=(%0d,%0d) occ=(%0d,%0d) want all 0",
               occ_req, food_valid, placed, busy, board_full, box_x, box_y, occ_x, occ_y);
    end
    obs_q.delete();
    s = cyc + 1; fixed[s + 1] = 9'h0A3; fixed[s + 2] = 9'h011; rst_n = 1;
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0) begin n_bad++; $display("FAIL reset_done: got timeout want placement"); end
    n_cmp++; if (e - s !== 4 || e !== exp_edge) begin n_bad++; $display("FAIL reset_latency: got edge %0d want 4", e - s); end
    n_cmp++; if (box_x !== 560 || box_y !== 272) begin n_bad++; $display("FAIL reset_box: got (%0d,%0d) want (560,272)", box_x, box_y); end
    n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 35 * 32 + 17) begin n_bad++; $display("FAIL reset_query: got %0d queries first %0d want 1 of %0d", obs_q.size(), obs_q[0], 35 * 32 + 17); end
    n_cmp++; if (food_valid !== 1 || npl !== 1) begin n_bad++; $display("FAIL reset_valid: got fv=%b placed=%0d want 1/1", food_valid, npl); end
  endtask

  task automatic test_out_of_range();
    int s, e, npl; bit to;
    fill_occ(0); lat = 1;
    @(negedge clk);
    s = cyc + 2;
    fixed[s + 1] = 9'h1ED; fixed[s + 2] = 9'h0ED; fixed[s + 3] = 9'h12D;
    fixed[s + 4] = 9'h1CA; fixed[s + 5] = 9'h1E5;
    pulse_eat(s);
    n_cmp++; if (food_valid !== 0 || busy !== 1) begin n_bad++; $display("FAIL oor_eat: got fv=%b busy=%b want 0/1", food_valid, busy); end
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0 || e !== exp_edge || e - s !== 7) begin n_bad++; $display("FAIL oor_timing: got edge %0d want %0d", e - s, exp_edge - s); end
    n_cmp++; if (box_x !== 160 || box_y !== 80) begin n_bad++; $display("FAIL oor_box: got (%0d,%0d) want (160,80)", box_x, box_y); end
    n_cmp++; if (q_diff() !== 0 || obs_q.size() !== 1) begin n_bad++; $display("FAIL oor_query: got %0d queries want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_scan();
    int s, e, npl; bit to;
    int want[4] = '{1277, 0, 32, 64};
    fill_occ(100); occ[2][0] = 0; lat = 1;
    @(negedge clk);
    s = cyc + 2;
    for (int k = 0; k < 8; k++) begin
      fixed[s + 1 + 4 * k] = 9'(k < 7 ? 5 + k : 39);
      fixed[s + 2 + 4 * k] = 9'(k < 7 ? 5 + k : 29);
    end
    pulse_eat(s);
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0 || e !== exp_edge) begin n_bad++; $display("FAIL scan_timing: got edge %0d want %0d", e - s, exp_edge - s); end
    n_cmp++; if (obs_q.size() !== 12) begin n_bad++; $display("FAIL scan_count: got %0d queries want 12", obs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_q[8 + i] !== want[i]) begin n_bad++; $display("FAIL scan_cell%0d: got (%0d,%0d) want (%0d,%0d)", i, obs_q[8 + i] / 32, obs_q[8 + i] % 32, want[i] / 32, want[i] % 32); end
    end
    n_cmp++; if (box_x !== 32 || box_y !== 0 || npl !== 1) begin n_bad++; $display("FAIL scan_box: got (%0d,%0d) placed=%0d want (32,0) 1", box_x, box_y, npl); end
  endtask

  task automatic test_eat_ignored();
    int s, e, npl, bad = 0; bit to;
    fill_occ(60); occ[$urandom_range(0, 39)][$urandom_range(0, 29)] = 0; lat = 2;
    pulse_eat(s);
    eat = 1; if (!busy) bad++;
    @(negedge clk); eat = 0;
    @(negedge clk); eat = 1; if (!busy || food_valid) bad++;
    @(negedge clk); eat = 0;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL ign_busy: got %0d non-busy samples want 0", bad); end
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0 || e !== exp_edge) begin n_bad++; $display("FAIL ign_timing: got edge %0d want %0d", e - s, exp_edge - s); end
    n_cmp++; if (q_diff() !== 0) begin n_bad++; $display("FAIL ign_query: got %0d queries want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (box_x !== 10'(exp_x * 16) || box_y !== 10'(exp_y * 16)) begin n_bad++; $display("FAIL ign_box: got (%0d,%0d) want (%0d,%0d)", box_x, box_y, exp_x * 16, exp_y * 16); end
    repeat (10) begin @(negedge clk); if (placed) npl++; if (busy || !food_valid) bad++; end
    n_cmp++; if (npl !== 1 || bad !== 0) begin n_bad++; $display("FAIL ign_restart: got placed=%0d busy/fv glitches=%0d want 1/0", npl, bad); end
  endtask

  task automatic test_random();
    int s, e, npl; bit to;
    for (int it = 0; it < 6; it++) begin
      fill_occ(it == 0 ? 0 : $urandom_range(40, 97));
      occ[$urandom_range(0, 39)][$urandom_range(0, 29)] = 0;
      lat = $urandom_range(1, 3);
      repeat ($urandom_range(1, 4)) @(negedge clk);
      pulse_eat(s);
      wait_done(e, npl, to); model(s);
      n_cmp++; if (to !== 0 || e !== exp_edge || npl !== 1) begin n_bad++; $display("FAIL rand%0d_timing: got edge %0d placed=%0d want %0d 1", it, e - s, npl, exp_edge - s); end
      n_cmp++; if (q_diff() !== 0) begin n_bad++; $display("FAIL rand%0d_query: got %0d queries want %0d", it, obs_q.size(), exp_q.size()); end
      n_cmp++; if (box_x !== 10'(exp_x * 16) || box_y !== 10'(exp_y * 16)) begin n_bad++; $display("FAIL rand%0d_box: got (%0d,%0d) want (%0d,%0d)", it, box_x, box_y, exp_x * 16, exp_y * 16); end
    end
  endtask

  task automatic test_full();
    int s, e, npl, bad = 0; bit to;
    fill_occ(100); lat = 1;
    pulse_eat(s);
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0 || e !== exp_edge || exp_full !== 1) begin n_bad++; $display("FAIL full_timing: got edge %0d want %0d", e - s, exp_edge - s); end
    n_cmp++; if (obs_q.size() - n_rand !== 1200) begin n_bad++; $display("FAIL full_scans: got %0d scan queries want 1200", obs_q.size() - n_rand); end
    n_cmp++; if (q_diff() !== 0) begin n_bad++; $display("FAIL full_query: got %0d queries want %0d", obs_q.size(), exp_q.size()); end
    n_cmp++; if (board_full !== 1 || food_valid !== 0 || npl !== 0) begin n_bad++; $display("FAIL full_flags: got full=%b fv=%b placed=%0d want 1/0/0", board_full, food_valid, npl); end
    pulse_eat(s);
    repeat (20) begin @(negedge clk); if (placed || busy || occ_req || food_valid || !board_full) bad++; end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL full_sticky: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_reset_mid_query();
    int s, e, npl; bit to, got = 0;
    resp_en = 0; occ_ack = 0; occ_hit = 0; lat = 1; fill_occ(0);
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk); got = occ_req; end
    n_cmp++; if (got !== 1 || board_full !== 0) begin n_bad++; $display("FAIL mid_reach: got req=%b full=%b want 1/0", got, board_full); end
    #1 rst_n = 0;
    #1;
    n_cmp++; if (occ_req !== 0 || busy !== 0) begin n_bad++; $display("FAIL mid_async: got req=%b busy=%b want 0/0", occ_req, busy); end
    @(negedge clk);
    s = cyc + 1; fixed[s + 1] = 9'h003; fixed[s + 2] = 9'h004; obs_q.delete(); rst_n = 1;
    @(negedge clk); occ_ack = 1; occ_hit = 0;
    @(negedge clk); occ_ack = 0; resp_en = 1;
    wait_done(e, npl, to); model(s);
    n_cmp++; if (to !== 0 || e !== exp_edge || e - s !== 4) begin n_bad++; $display("FAIL mid_timing: got edge %0d want 4", e - s); end
    n_cmp++; if (box_x !== 48 || box_y !== 64 || npl !== 1) begin n_bad++; $display("FAIL mid_box: got (%0d,%0d) placed=%0d want (48,64) 1", box_x, box_y, npl); end
    n_cmp++; if (q_diff() !== 0) begin n_bad++; $display("FAIL mid_query: got %0d queries want %0d", obs_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_scan();
    test_eat_ignored();
    test_random();
    test_full();
    test_reset_mid_query();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cake_ctrl.md
# cake_ctrl

Sequencer for cake (food) placement on the snake playfield. On each eat event, and once after reset, it samples a free-running random number, converts it to a grid cell, and checks that cell against the snake-body occupancy store through a request/acknowledge handshake. It retries on rejection and falls back to a linear scan when retries run out, so a free cell is always found if one exists. It sits between the random-number generator, the snake-body store and the VGA/draw logic, which consumes `box_x`/`box_y`.

## Interface
- `GRID_W`, 40, playfield width in cells
- `GRID_H`, 30, playfield height in cells
- `CELL_LOG2`, 4, log2 of cell size in pixels (16 px)
- `MAX_TRIES`, 8, random attempts before fallback scan
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `rand_num`  in  9  free-running random value, new value every cycle
- `eat`  in  1  single-cycle pulse: snake head reached current cake
- `occ_req`  out  1  occupancy query valid
- `occ_x`  out  6  queried cell column
- `occ_y`  out  5  queried cell row
- `occ_ack`  in  1  single-cycle response strobe
- `occ_hit`  in  1  cell occupied by snake; valid only with `occ_ack`
- `box_x`  out  10  cake pixel x (column << CELL_LOG2)
- `box_y`  out  10  cake pixel y (row << CELL_LOG2)
- `food_valid`  out  1  cake on board at `box_x`/`box_y`
- `placed`  out  1  one-cycle pulse when a new cake is placed
- `busy`  out  1  placement in progress
- `board_full`  out  1  no free cell exists; sticky until reset

## Operation
- States: IDLE, SAMPLE_X, SAMPLE_Y, QUERY, SCAN, PLACED, FULL.
- Reset: state SAMPLE_X on the first edge after `rst_n` rises, so the first cake spawns automatically. `box_x`/`box_y`/`occ_x`/`occ_y` = 0. `food_valid`, `placed`, `busy`, `occ_req`, `board_full` = 0.
- IDLE: `eat` while `food_valid`=1 → clear `food_valid` and go to SAMPLE_X. `eat` while `food_valid`=0 is ignored.
- SAMPLE_X: capture cand_x = `rand_num[5:0]`. If cand_x ≥ GRID_W, count a failed try and stay in SAMPLE_X. Otherwise go to SAMPLE_Y.
- SAMPLE_Y: capture cand_y = `rand_num[4:0]`. If cand_y ≥ GRID_H, count a failed try and return to SAMPLE_X. Otherwise go to QUERY.
- QUERY: drive `occ_req`=1 with cand_x/cand_y and hold it stable until `occ_ack`.
  - Ack with `occ_hit`=0 → PLACED.
  - Ack with `occ_hit`=1 → count a failed try, then SAMPLE_X.
- Try counter: cleared when placement starts. When it reaches MAX_TRIES, go to SCAN instead of resampling. The scan starts at the last in-range candidate, or at (0,0) if no in-range candidate exists.
- SCAN: query the current cell with the same handshake.
  - Hit → next cell: x+1; at GRID_W-1, wrap x to 0 and increment y; at GRID_H-1, wrap y to 0.
  - Miss → PLACED.
  - If GRID_W*GRID_H consecutive hits occur (scan counter, 11 bits) → FULL.
- PLACED: load `box_x` = cell_x << CELL_LOG2 and `box_y` = cell_y << CELL_LOG2 (zero-extended to 10 bits). Assert `food_valid`=1 and `placed`=1 for this cycle, then go to IDLE.
- FULL: `board_full`=1 and `food_valid`=0; the block stays here until reset.
- `busy`=1 in SAMPLE_X, SAMPLE_Y, QUERY and SCAN.
- `eat` during busy/FULL: ignored.
- Reset mid-query: `occ_req` drops asynchronously. The responder must discard an outstanding query; a late `occ_ack` in any state other than QUERY/SCAN is ignored.

## Timing
- Best case, with ack one cycle after req:
  - eat sampled at edge 0
  - SAMPLE_X at cycle 1, SAMPLE_Y at cycle 2
  - `occ_req` at cycle 3, ack at cycle 4
  - `food_valid`/`placed` at cycle 5
- `food_valid` falls in the cycle after `eat` is sampled.
- `box_x`/`box_y` change only on entry to PLACED and hold otherwise, including through busy.
- Each query costs exactly 1 + ack-latency cycles; the block adds no idle cycle between successive scan queries.

## Structure
- Shared `snake_pkg`: GRID_W, GRID_H, CELL_LOG2, MAX_TRIES defaults, state enum type, and cell-coordinate widths (6/5 bits).
- One natural sub-module, `cake_scan_ctr`: wrap-around x/y cell stepper plus visited-cell counter, with load/step/full outputs.
- The FSM, try counter and handshake live in `cake_ctrl`.

## Test plan
- Reset release with responder always `occ_hit`=0 and `rand_num`=9'h0A3 then 9'h011 → cell (35,17) queried; `box_x`=560, `box_y`=272; `food_valid` at cycle 5.
- `rand_num[5:0]`=45 for three cycles, then 10/5, no hits → three failed tries, then cell (10,5); `box_x`=160, `box_y`=80.
- Responder hits every random query (MAX_TRIES=8), last candidate (39,29), free cell (2,0) → scan visits (39,29), (0,0), (1,0), (2,0); place at (2,0).
- All cells occupied → exactly 1200 scan queries after the tries, then `board_full`=1, `food_valid`=0; a further `eat` has no effect.
- `eat` pulsed while busy, and again while `food_valid`=0 → no restart, no extra `placed` pulse.
- `rst_n` low while `occ_req`=1, ack delivered after release → `occ_req` drops immediately, the late ack is ignored, and a fresh placement completes normally.
